// File: rtl/axis_dwidth_pkg.sv
// Shared helpers for the AXI4-Stream width converters (upsizer and downsizer).
package axis_dwidth_pkg;

    // Number of bits needed to index 'value' distinct lanes (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Bit offset of lane 'lane' inside a wide word built from 'width'-bit lanes.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/my_axis_dwidth_downsize.sv
// AXI4-Stream downsizer: one wide beat of WIDTH*NUM_REG bits is replayed as
// up to NUM_REG narrow beats, lane 0 first. A single holding register plus a
// lane index is the whole datapath; a new wide beat may load in the same cycle
// the final lane drains, so the narrow side runs without bubbles.
module my_axis_dwidth_downsize
    import axis_dwidth_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_REG = 2
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [WIDTH*NUM_REG-1:0]   s_axis_tdata,
    input  logic [NUM_REG-1:0]         s_axis_tkeep,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tlast
);

    localparam int                DATA_W   = WIDTH * NUM_REG;
    localparam int                IDX_W    = clog2(NUM_REG);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REG - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    logic [DATA_W-1:0]  data_r;
    logic [NUM_REG-1:0] keep_r;
    logic               last_r;
    logic [IDX_W-1:0]   idx_r;
    logic               full_r;

    logic [IDX_W-1:0]   next_idx_s;
    logic               final_lane_s;
    logic               s_ready_s;
    logic               accept_s;
    logic               drain_s;
    logic [WIDTH-1:0]   lane_data_s;

    // Decide whether the lane on the output is the last one to emit from the held word.
    // next_idx_s wraps to 0 at the top lane, but the idx==LAST_IDX term already covers that case.
    always_comb begin
        next_idx_s   = idx_r + IDX_ONE;
        final_lane_s = (idx_r == LAST_IDX) || !keep_r[next_idx_s];
    end

    // Handshake qualifiers; upstream ready is held low during reset.
    always_comb begin
        s_ready_s = !areset && (!full_r || (m_axis_tready && final_lane_s));
        accept_s  = s_axis_tvalid && s_ready_s;
        drain_s   = full_r && m_axis_tready;
    end

    // Select the current lane from the held word.
    always_comb begin
        lane_data_s = data_r[lane_lsb(int'(idx_r), WIDTH) +: WIDTH];
    end

    // Holding register: load on accept, step the lane index on narrow handshakes.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            data_r <= '0;
            keep_r <= '0;
            last_r <= 1'b0;
            idx_r  <= '0;
            full_r <= 1'b0;
        end else if (accept_s) begin
            data_r <= s_axis_tdata;
            keep_r <= s_axis_tkeep;
            last_r <= s_axis_tlast;
            idx_r  <= '0;
            full_r <= 1'b1;
        end else if (drain_s && final_lane_s) begin
            idx_r  <= '0;
            full_r <= 1'b0;
        end else if (drain_s) begin
            idx_r  <= next_idx_s;
        end else begin
            idx_r  <= idx_r;
            full_r <= full_r;
        end
    end

    // Output drive straight from the held state.
    always_comb begin
        s_axis_tready = s_ready_s;
        m_axis_tvalid = full_r;
        m_axis_tdata  = lane_data_s;
        m_axis_tlast  = last_r && final_lane_s;
    end

endmodule

// File: tb/tb_my_axis_dwidth_downsize.sv
// Directed bench for my_axis_dwidth_downsize: a NUM_REG=2 instance and a
// NUM_REG=4 instance share clock and reset. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_my_axis_dwidth_downsize;

    logic          aclk;
    logic          areset;

    logic          s2_tvalid;
    logic          s2_tready;
    logic [63:0]   s2_tdata;
    logic [1:0]    s2_tkeep;
    logic          s2_tlast;
    logic          m2_tvalid;
    logic          m2_tready;
    logic [31:0]   m2_tdata;
    logic          m2_tlast;

    logic          s4_tvalid;
    logic          s4_tready;
    logic [127:0]  s4_tdata;
    logic [3:0]    s4_tkeep;
    logic          s4_tlast;
    logic          m4_tvalid;
    logic          m4_tready;
    logic [31:0]   m4_tdata;
    logic          m4_tlast;

    int errors;
    int checks;

    my_axis_dwidth_downsize #(.WIDTH(32), .NUM_REG(2)) dut2 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready), .s_axis_tdata(s2_tdata),
        .s_axis_tkeep(s2_tkeep), .s_axis_tlast(s2_tlast),
        .m_axis_tvalid(m2_tvalid), .m_axis_tready(m2_tready), .m_axis_tdata(m2_tdata),
        .m_axis_tlast(m2_tlast)
    );

    my_axis_dwidth_downsize #(.WIDTH(32), .NUM_REG(4)) dut4 (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s4_tvalid), .s_axis_tready(s4_tready), .s_axis_tdata(s4_tdata),
        .s_axis_tkeep(s4_tkeep), .s_axis_tlast(s4_tlast),
        .m_axis_tvalid(m4_tvalid), .m_axis_tready(m4_tready), .m_axis_tdata(m4_tdata),
        .m_axis_tlast(m4_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic test_reset();
        areset = 1'b0;
        #1 areset = 1'b1;
        #2;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%0b exp=0", m2_tvalid); end
        checks++; if (m2_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m2_tdata); end
        checks++; if (m2_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%0b exp=0", m2_tlast); end
        checks++; if (s2_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready got=%0b exp=0", s2_tready); end
        checks++; if (m4_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid4 got=%0b exp=0", m4_tvalid); end
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        #1;
        checks++; if (s2_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready got=%0b exp=1", s2_tready); end
        checks++; if (s4_tready !== 1'b1) begin errors++; $display("FAIL release_s_tready4 got=%0b exp=1", s4_tready); end
    endtask

    task automatic test_single_word();
        @(negedge aclk);
        s2_tvalid = 1'b1; s2_tdata = 64'h00000074_00000064; s2_tkeep = 2'b11; s2_tlast = 1'b1;
        m2_tready = 1'b1;
        #1;
        checks++; if (s2_tready !== 1'b1) begin errors++; $display("FAIL single_accept_ready got=%0b exp=1", s2_tready); end
        @(negedge aclk);
        s2_tvalid = 1'b0;
        #1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 32'h64 || m2_tlast !== 1'b0)
            begin errors++; $display("FAIL single_lane0 got v=%0b d=%h l=%0b exp v=1 d=64 l=0", m2_tvalid, m2_tdata, m2_tlast); end
        checks++; if (s2_tready !== 1'b0) begin errors++; $display("FAIL single_ready_lane0 got=%0b exp=0", s2_tready); end
        @(negedge aclk);
        #1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 32'h74 || m2_tlast !== 1'b1)
            begin errors++; $display("FAIL single_lane1 got v=%0b d=%h l=%0b exp v=1 d=74 l=1", m2_tvalid, m2_tdata, m2_tlast); end
        checks++; if (s2_tready !== 1'b1) begin errors++; $display("FAIL single_ready_lane1 got=%0b exp=1", s2_tready); end
        @(negedge aclk);
        #1;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL single_idle got=%0b exp=0", m2_tvalid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] words [3];
        logic [31:0] exp_data [7];
        logic        exp_rdy  [7];
        logic        exp_last [7];
        int          wi;
        logic        acc;
        words[0] = 64'h00000074_00000064;
        words[1] = 64'h00000094_00000084;
        words[2] = 64'h000000B4_000000A4;
        exp_data = '{32'h0, 32'h64, 32'h74, 32'h84, 32'h94, 32'hA4, 32'hB4};
        exp_rdy  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wi = 0;
        m2_tready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge aclk);
            s2_tvalid = (wi < 3);
            s2_tdata  = words[(wi < 3) ? wi : 2];
            s2_tkeep  = 2'b11;
            s2_tlast  = (wi == 2);
            #1;
            checks++; if (s2_tready !== exp_rdy[c])
                begin errors++; $display("FAIL b2b_ready c=%0d got=%0b exp=%0b", c, s2_tready, exp_rdy[c]); end
            if (c >= 1) begin
                checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== exp_data[c] || m2_tlast !== exp_last[c])
                    begin errors++; $display("FAIL b2b_beat c=%0d got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                                             c, m2_tvalid, m2_tdata, m2_tlast, exp_data[c], exp_last[c]); end
            end
            acc = s2_tvalid && s2_tready;
            if (acc) wi++;
        end
        @(negedge aclk);
        s2_tvalid = 1'b0;
        #1;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%0b exp=0", m2_tvalid); end
    endtask

    task automatic test_backpressure();
        logic        rdy_seq [4];
        logic [31:0] exp_data [4];
        logic        exp_srdy [4];
        rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_data = '{32'hC1, 32'hD2, 32'hD2, 32'hD2};
        exp_srdy = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge aclk);
        s2_tvalid = 1'b1; s2_tdata = 64'h000000D2_000000C1; s2_tkeep = 2'b11; s2_tlast = 1'b0;
        m2_tready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge aclk);
            s2_tvalid = 1'b0;
            m2_tready = rdy_seq[c];
            #1;
            checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== exp_data[c] || m2_tlast !== 1'b0)
                begin errors++; $display("FAIL bp_beat c=%0d got v=%0b d=%h l=%0b exp v=1 d=%h l=0",
                                         c, m2_tvalid, m2_tdata, m2_tlast, exp_data[c]); end
            checks++; if (s2_tready !== exp_srdy[c])
                begin errors++; $display("FAIL bp_s_ready c=%0d got=%0b exp=%0b", c, s2_tready, exp_srdy[c]); end
        end
        @(negedge aclk);
        m2_tready = 1'b1;
        #1;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0b exp=0", m2_tvalid); end
    endtask

    task automatic test_partial_last();
        @(negedge aclk);
        s2_tvalid = 1'b1; s2_tdata = 64'h0000DEAD_0000BEEF; s2_tkeep = 2'b01; s2_tlast = 1'b1;
        m2_tready = 1'b1;
        @(negedge aclk);
        s2_tvalid = 1'b0;
        #1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 32'h0000BEEF || m2_tlast !== 1'b1)
            begin errors++; $display("FAIL partial_beat got v=%0b d=%h l=%0b exp v=1 d=0000beef l=1", m2_tvalid, m2_tdata, m2_tlast); end
        checks++; if (s2_tready !== 1'b1) begin errors++; $display("FAIL partial_s_ready got=%0b exp=1", s2_tready); end
        @(negedge aclk);
        #1;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL partial_no_lane1 got=%0b exp=0", m2_tvalid); end
    endtask

    task automatic test_reset_mid_word();
        @(negedge aclk);
        s2_tvalid = 1'b1; s2_tdata = 64'h00000022_00000011; s2_tkeep = 2'b11; s2_tlast = 1'b1;
        m2_tready = 1'b1;
        @(negedge aclk);
        s2_tvalid = 1'b0;
        #1;
        checks++; if (m2_tdata !== 32'h11) begin errors++; $display("FAIL midrst_lane0 got=%h exp=11", m2_tdata); end
        @(negedge aclk);
        m2_tready = 1'b0;
        #1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 32'h22)
            begin errors++; $display("FAIL midrst_pending got v=%0b d=%h exp v=1 d=22", m2_tvalid, m2_tdata); end
        areset = 1'b1;
        #1;
        checks++; if (m2_tvalid !== 1'b0 || m2_tlast !== 1'b0)
            begin errors++; $display("FAIL midrst_async got v=%0b l=%0b exp v=0 l=0", m2_tvalid, m2_tlast); end
        @(negedge aclk);
        areset = 1'b0;
        m2_tready = 1'b1;
        s2_tvalid = 1'b1; s2_tdata = 64'h00000044_00000033; s2_tkeep = 2'b11; s2_tlast = 1'b1;
        #1;
        checks++; if (m2_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_discard got=%0b exp=0", m2_tvalid); end
        @(negedge aclk);
        s2_tvalid = 1'b0;
        #1;
        checks++; if (m2_tvalid !== 1'b1 || m2_tdata !== 32'h33 || m2_tlast !== 1'b0)
            begin errors++; $display("FAIL midrst_new_lane0 got v=%0b d=%h l=%0b exp v=1 d=33 l=0", m2_tvalid, m2_tdata, m2_tlast); end
        @(negedge aclk);
        #1;
        checks++; if (m2_tdata !== 32'h44 || m2_tlast !== 1'b1)
            begin errors++; $display("FAIL midrst_new_lane1 got d=%h l=%0b exp d=44 l=1", m2_tdata, m2_tlast); end
        @(negedge aclk);
    endtask

    task automatic test_four_lanes();
        logic [127:0] data_t [3];
        logic [3:0]   keep_t [3];
        logic         last_t [3];
        int           nbeat_t [3];
        int           last_lane_t [3];
        data_t[0] = {32'h4, 32'h3, 32'h2, 32'h1};  keep_t[0] = 4'b1111; last_t[0] = 1'b1; nbeat_t[0] = 4; last_lane_t[0] = 3;
        data_t[1] = {32'h8, 32'h7, 32'h6, 32'h5};  keep_t[1] = 4'b0111; last_t[1] = 1'b0; nbeat_t[1] = 3; last_lane_t[1] = -1;
        data_t[2] = {32'hC, 32'hB, 32'hA, 32'h9};  keep_t[2] = 4'b1011; last_t[2] = 1'b1; nbeat_t[2] = 2; last_lane_t[2] = 1;
        m4_tready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            @(negedge aclk);
            s4_tvalid = 1'b1; s4_tdata = data_t[w]; s4_tkeep = keep_t[w]; s4_tlast = last_t[w];
            for (int b = 0; b < nbeat_t[w]; b++) begin
                @(negedge aclk);
                s4_tvalid = 1'b0;
                #1;
                checks++; if (m4_tvalid !== 1'b1 || m4_tdata !== data_t[w][b*32 +: 32] || m4_tlast !== (b == last_lane_t[w]))
                    begin errors++; $display("FAIL nr4_beat w=%0d b=%0d got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                                             w, b, m4_tvalid, m4_tdata, m4_tlast, data_t[w][b*32 +: 32], (b == last_lane_t[w])); end
                checks++; if (s4_tready !== (b == nbeat_t[w] - 1))
                    begin errors++; $display("FAIL nr4_s_ready w=%0d b=%0d got=%0b exp=%0b", w, b, s4_tready, (b == nbeat_t[w] - 1)); end
            end
            @(negedge aclk);
            #1;
            checks++; if (m4_tvalid !== 1'b0) begin errors++; $display("FAIL nr4_idle w=%0d got=%0b exp=0", w, m4_tvalid); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        s2_tvalid = 1'b0; s2_tdata = '0; s2_tkeep = '0; s2_tlast = 1'b0; m2_tready = 1'b0;
        s4_tvalid = 1'b0; s4_tdata = '0; s4_tkeep = '0; s4_tlast = 1'b0; m4_tready = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_partial_last();
        test_reset_mid_word();
        test_four_lanes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
